idma_desc64_chan_arb: RTL and testbench
=======================================

# idma_desc64_chan_arb

Multi-channel request arbiter and response router placed between `NumChannels` descriptor front-ends (`idma_desc64_top` instances) and a single iDMA backend. It generalises the single-front-end/single-backend pairing to N independent descriptor channels sharing one backend. It forwards one `idma_req_t` per grant, records the granted channel in an in-order route FIFO, and steers each backend response back to the channel that issued it. It also provides per-channel busy and outstanding counts.

## Interface
- `NumChannels`, 2: number of front-end channels, ≥ 2.
- `RspFifoDepth`, 8: maximum outstanding requests in the backend; route FIFO depth, power of two, ≥ 2.
- `idma_req_t`, logic: backend request type.
- `idma_rsp_t`, logic: backend response type.
- `ChIdxWidth`, `$clog2(NumChannels)`: do not override.
- `CntWidth`, `$clog2(RspFifoDepth+1)`: do not override.

Ports:
- `clk_i`  in  1  clock.
- `rst_ni`  in  1  asynchronous active-low reset.
- `ch_req_i`  in  `[NumChannels] idma_req_t`  per-channel requests.
- `ch_req_valid_i`  in  NumChannels  request valid.
- `ch_req_ready_o`  out  NumChannels  request ready.
- `ch_rsp_o`  out  `[NumChannels] idma_rsp_t`  per-channel responses (all copies of `be_rsp_i`).
- `ch_rsp_valid_o`  out  NumChannels  response valid, one-hot or zero.
- `ch_rsp_ready_i`  in  NumChannels  response ready.
- `be_req_o`  out  idma_req_t  request to backend.
- `be_req_valid_o` / `be_req_ready_i`  out / in  1  backend request handshake.
- `be_rsp_i`  in  idma_rsp_t  backend response.
- `be_rsp_valid_i` / `be_rsp_ready_o`  in / out  1  backend response handshake.
- `be_busy_i`  in  1  OR-reduced backend busy.
- `ch_busy_o`  out  NumChannels  channel has a pending or outstanding request.
- `ch_outstanding_o`  out  `[NumChannels][CntWidth]`  per-channel outstanding count.
- `rsp_unexpected_o`  out  1  sticky flag: response arrived with route FIFO empty.

## Operation
- **Arbitration:** round-robin over `ch_req_valid_i`. The search starts at pointer `rr_q`. After a backend handshake, `rr_q` ← granted index + 1 mod `NumChannels`.
- **Grant lock:**
  - While `be_req_valid_o` is high and `be_req_ready_i` is low, the grant is frozen in `lock_q`/`lock_idx_q`. `be_req_o` must not change (AXI-style stability).
  - The lock releases on handshake.
  - If the locked channel drops valid (protocol violation), the output still holds the locked channel's current data. Verification asserts this never happens.
- **Issue condition:** `be_req_valid_o` = (any valid or lock) & !route_full.
  - `ch_req_ready_o[g]` = `be_req_ready_i` & !route_full for the granted channel only; all other bits are 0.
- **Route FIFO:**
  - A request handshake pushes the granted index.
  - A response handshake pops the head.
  - Push and pop may occur in the same cycle; occupancy is then unchanged.
  - Push is never accepted while full, even if a pop happens that cycle.
- **Response routing:**
  - With the FIFO not empty: `ch_rsp_valid_o[head]` = `be_rsp_valid_i`, and `be_rsp_ready_o` = `ch_rsp_ready_i[head]`.
  - With the FIFO empty: `be_rsp_ready_o` = 0, all `ch_rsp_valid_o` = 0, and `rsp_unexpected_o` is set if `be_rsp_valid_i` is high. The flag is cleared only by reset.
- **Counters:**
  - `ch_outstanding_o[i]` increments on a request handshake from channel i and decrements on a response handshake routed to i. Both in the same cycle for the same channel leaves it unchanged.
  - Counters saturate by construction (≤ `RspFifoDepth`).
- **Busy:** `ch_busy_o[i]` = `ch_req_valid_i[i]` | (`ch_outstanding_o[i]` ≠ 0) | (`be_busy_i` & `ch_outstanding_o[i]` ≠ 0). This is combinational.

## Timing
- Request and response paths are combinational pass-through, with zero added latency. A channel request can reach the backend in the same cycle.
- Registered state: `rr_q`, `lock_q`, `lock_idx_q`, FIFO pointers and count, per-channel counters, `rsp_unexpected_o`.
- Reset values:
  - `rr_q` = 0, lock = 0, FIFO empty, counters = 0, `rsp_unexpected_o` = 0.
  - Therefore after reset: `be_req_valid_o` = 0 with no valid inputs, all `ch_rsp_valid_o` = 0, `be_rsp_ready_o` = 0.
- Reset asserted mid-transfer clears all state immediately (asynchronously). Outstanding routes are lost; the integrator must reset the backend together with this block.

## Configuration
- `IDMA_CHAN_ARB_FIXED_PRIO_EN`:
  - Defined: fixed priority, lowest index wins. `rr_q` is not implemented and pointer updates are removed.
  - Undefined (default): round-robin as above.
  - The lock, routing, and counter behaviour is identical in both modes.

## Test plan
- **RR fairness:** `NumChannels`=4, all channels valid continuously, `be_req_ready_i`=1. Grant order is 0,1,2,3,0,… with one grant per cycle. With FIXED_PRIO_EN, channel 0 wins every cycle.
- **Lock stability:** channels 1 and 3 valid, `be_req_ready_i`=0 for 5 cycles. `be_req_o` equals `ch_req_i[1]` throughout; channel 1 handshakes in cycle 6, then channel 3 in cycle 7.
- **Route full:** `RspFifoDepth`=4, 4 requests issued with no responses. The 5th request sees `be_req_valid_o`=0. One response pop then allows the 5th request on the following cycle.
- **Routing order:** issue ch2, ch0, ch2, then return 3 responses. `ch_rsp_valid_o` sequence is 0b0100, 0b0001, 0b0100, and `ch_outstanding_o[2]` goes 2→1→0.
- **Backpressure:** head is ch1 with `ch_rsp_ready_i[1]`=0 for 3 cycles. `be_rsp_ready_o`=0 for those cycles and the FIFO is not popped.
- **Unexpected response:** `be_rsp_valid_i`=1 with the FIFO empty. `rsp_unexpected_o`=1 from the next cycle and stays high until `rst_ni`=0.

Source files
------------

// File: rtl/idma_desc64_chan_arb.sv
// Shares one iDMA backend among NumChannels descriptor front-ends and routes responses back in order.
// Define IDMA_CHAN_ARB_FIXED_PRIO_EN to select fixed lowest-index priority instead of round-robin.
module idma_desc64_chan_arb #(
  parameter int unsigned NumChannels  = 2,
  parameter int unsigned RspFifoDepth = 8,
  parameter type         idma_req_t   = logic,
  parameter type         idma_rsp_t   = logic,
  parameter int unsigned ChIdxWidth   = $clog2(NumChannels),
  parameter int unsigned CntWidth     = $clog2(RspFifoDepth + 1)
) (
  input  logic                                  clk_i,
  input  logic                                  rst_ni,
  input  idma_req_t [NumChannels-1:0]           ch_req_i,
  input  logic      [NumChannels-1:0]           ch_req_valid_i,
  output logic      [NumChannels-1:0]           ch_req_ready_o,
  output idma_rsp_t [NumChannels-1:0]           ch_rsp_o,
  output logic      [NumChannels-1:0]           ch_rsp_valid_o,
  input  logic      [NumChannels-1:0]           ch_rsp_ready_i,
  output idma_req_t                             be_req_o,
  output logic                                  be_req_valid_o,
  input  logic                                  be_req_ready_i,
  input  idma_rsp_t                             be_rsp_i,
  input  logic                                  be_rsp_valid_i,
  output logic                                  be_rsp_ready_o,
  input  logic                                  be_busy_i,
  output logic      [NumChannels-1:0]           ch_busy_o,
  output logic      [NumChannels-1:0][CntWidth-1:0] ch_outstanding_o,
  output logic                                  rsp_unexpected_o
);

  localparam int unsigned PtrWidth = $clog2(RspFifoDepth);

  typedef logic [ChIdxWidth-1:0] idx_t;
  typedef logic [PtrWidth-1:0]   ptr_t;
  typedef logic [CntWidth-1:0]   cnt_t;

  logic  arb_valid;
  idx_t  arb_idx;
  logic  lock_q;
  idx_t  lock_idx_q;
  logic  gnt_any;
  idx_t  gnt_idx;
  logic  req_hs;
  logic  rsp_hs;

  idx_t  route_mem [RspFifoDepth];
  ptr_t  wr_ptr_q, rd_ptr_q;
  cnt_t  fifo_cnt_q;
  logic  fifo_full, fifo_empty;
  idx_t  head_idx;

  logic [NumChannels-1:0][CntWidth-1:0] cnt_d, cnt_q;

`ifdef IDMA_CHAN_ARB_FIXED_PRIO_EN
  // Lowest valid index wins; descending scan leaves the lowest as the final assignment.
  always_comb begin
    arb_valid = 1'b0;
    arb_idx   = '0;
    for (int i = NumChannels - 1; i >= 0; i--) begin
      if (ch_req_valid_i[i]) begin
        arb_valid = 1'b1;
        arb_idx   = ChIdxWidth'(i);
      end
    end
  end
`else
  idx_t rr_q;

  // Round-robin search from rr_q; descending offset scan keeps the nearest candidate.
  always_comb begin
    arb_valid = 1'b0;
    arb_idx   = '0;
    for (int k = NumChannels - 1; k >= 0; k--) begin
      if (ch_req_valid_i[(int'(rr_q) + k) % int'(NumChannels)]) begin
        arb_valid = 1'b1;
        arb_idx   = ChIdxWidth'((int'(rr_q) + k) % int'(NumChannels));
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_q <= '0;
    end else if (req_hs) begin
      rr_q <= (gnt_idx == ChIdxWidth'(NumChannels - 1)) ? '0 : gnt_idx + ChIdxWidth'(1);
    end
  end
`endif

  assign gnt_any        = lock_q | arb_valid;
  assign gnt_idx        = lock_q ? lock_idx_q : arb_idx;
  assign fifo_full      = (fifo_cnt_q == CntWidth'(RspFifoDepth));
  assign fifo_empty     = (fifo_cnt_q == '0);
  assign be_req_o       = ch_req_i[gnt_idx];
  assign be_req_valid_o = gnt_any & ~fifo_full;
  assign req_hs         = be_req_valid_o & be_req_ready_i;

  always_comb begin
    ch_req_ready_o = '0;
    ch_req_ready_o[gnt_idx] = gnt_any & be_req_ready_i & ~fifo_full;
  end

  // Freeze the grant while the backend stalls an offered request.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
    end else if (req_hs) begin
      lock_q     <= 1'b0;
    end else if (be_req_valid_o) begin
      lock_q     <= 1'b1;
      lock_idx_q <= gnt_idx;
    end
  end

  assign head_idx       = route_mem[rd_ptr_q];
  assign be_rsp_ready_o = ~fifo_empty & ch_rsp_ready_i[head_idx];
  assign rsp_hs         = be_rsp_valid_i & be_rsp_ready_o;
  assign ch_rsp_o       = {NumChannels{be_rsp_i}};

  always_comb begin
    ch_rsp_valid_o = '0;
    if (!fifo_empty) ch_rsp_valid_o[head_idx] = be_rsp_valid_i;
  end

  always_ff @(posedge clk_i) begin
    if (req_hs) route_mem[wr_ptr_q] <= gnt_idx;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q         <= '0;
      rd_ptr_q         <= '0;
      fifo_cnt_q       <= '0;
      rsp_unexpected_o <= 1'b0;
    end else begin
      if (req_hs) wr_ptr_q <= wr_ptr_q + PtrWidth'(1);
      if (rsp_hs) rd_ptr_q <= rd_ptr_q + PtrWidth'(1);
      fifo_cnt_q <= fifo_cnt_q + CntWidth'(req_hs) - CntWidth'(rsp_hs);
      if (fifo_empty && be_rsp_valid_i) rsp_unexpected_o <= 1'b1;
    end
  end

  // Per-channel outstanding counters and busy flags.
  always_comb begin
    cnt_d     = cnt_q;
    ch_busy_o = '0;
    for (int i = 0; i < int'(NumChannels); i++) begin
      cnt_d[i] = cnt_q[i]
               + CntWidth'(req_hs && (gnt_idx == ChIdxWidth'(i)))
               - CntWidth'(rsp_hs && (head_idx == ChIdxWidth'(i)));
      ch_busy_o[i] = ch_req_valid_i[i] | (cnt_q[i] != '0) | (be_busy_i & (cnt_q[i] != '0));
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign ch_outstanding_o = cnt_q;

endmodule

// File: tb/tb_idma_desc64_chan_arb.sv
// Scoreboard bench for idma_desc64_chan_arb: 4 channels, route FIFO depth 4.
module tb_idma_desc64_chan_arb;

  localparam int unsigned N  = 4;
  localparam int unsigned D  = 4;
  localparam int unsigned CW = $clog2(D + 1);

  typedef logic [15:0] req_t;
  typedef logic [7:0]  rsp_t;

  logic                  clk, rst_n;
  req_t [N-1:0]          ch_req;
  logic [N-1:0]          ch_req_valid, ch_req_ready;
  rsp_t [N-1:0]          ch_rsp;
  logic [N-1:0]          ch_rsp_valid, ch_rsp_ready, ch_busy;
  req_t                  be_req;
  logic                  be_req_valid, be_req_ready;
  rsp_t                  be_rsp;
  logic                  be_rsp_valid, be_rsp_ready, be_busy;
  logic [N-1:0][CW-1:0]  ch_out;
  logic                  rsp_unexp;

  idma_desc64_chan_arb #(
    .NumChannels (N),
    .RspFifoDepth(D),
    .idma_req_t  (req_t),
    .idma_rsp_t  (rsp_t)
  ) dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .ch_req_i        (ch_req),
    .ch_req_valid_i  (ch_req_valid),
    .ch_req_ready_o  (ch_req_ready),
    .ch_rsp_o        (ch_rsp),
    .ch_rsp_valid_o  (ch_rsp_valid),
    .ch_rsp_ready_i  (ch_rsp_ready),
    .be_req_o        (be_req),
    .be_req_valid_o  (be_req_valid),
    .be_req_ready_i  (be_req_ready),
    .be_rsp_i        (be_rsp),
    .be_rsp_valid_i  (be_rsp_valid),
    .be_rsp_ready_o  (be_rsp_ready),
    .be_busy_i       (be_busy),
    .ch_busy_o       (ch_busy),
    .ch_outstanding_o(ch_out),
    .rsp_unexpected_o(rsp_unexp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  int rr_m;
  bit lock_m;
  int lock_idx_m;
  int exp_q[$];
  int out_m[N];
  bit unexp_m;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    rr_m = 0; lock_m = 0; lock_idx_m = 0; unexp_m = 0;
    exp_q.delete();
    for (int i = 0; i < N; i++) out_m[i] = 0;
  endtask

  function automatic int exp_grant();
    int j;
    if (lock_m) return lock_idx_m;
    for (int k = 0; k < N; k++) begin
`ifdef IDMA_CHAN_ARB_FIXED_PRIO_EN
      j = k;
`else
      j = (rr_m + k) % N;
`endif
      if (ch_req_valid[j]) return j;
    end
    return -1;
  endfunction

  // Called at posedge+1 with inputs driven; checks at posedge+2, advances the model, returns at next posedge+1.
  task automatic tick();
    int g, head;
    bit issue, hs, pop, exp_brr;
    logic [N-1:0] exp_rdy, exp_rv;
    #1;
    g     = exp_grant();
    issue = (g >= 0) && (exp_q.size() < D);
    hs    = issue && be_req_ready;
    exp_rdy = '0;
    if (hs) exp_rdy[g] = 1'b1;
    check("be_req_valid", be_req_valid, issue);
    check("ch_req_ready", ch_req_ready, exp_rdy);
    if (issue) check("be_req_data", be_req, ch_req[g]);

    head    = (exp_q.size() > 0) ? exp_q[0] : -1;
    exp_rv  = '0;
    exp_brr = 1'b0;
    if (head >= 0) begin
      exp_rv[head] = be_rsp_valid;
      exp_brr      = ch_rsp_ready[head];
      check("ch_rsp_data", ch_rsp[head], be_rsp);
    end
    pop = (head >= 0) && be_rsp_valid && exp_brr;
    check("ch_rsp_valid", ch_rsp_valid, exp_rv);
    check("be_rsp_ready", be_rsp_ready, exp_brr);
    check("rsp_unexpected", rsp_unexp, unexp_m);
    for (int i = 0; i < N; i++) begin
      check($sformatf("outstanding%0d", i), ch_out[i], out_m[i]);
      check($sformatf("busy%0d", i), ch_busy[i], ch_req_valid[i] | (out_m[i] != 0));
    end

    if (pop) begin
      void'(exp_q.pop_front());
      out_m[head]--;
    end
    if (hs) begin
      exp_q.push_back(g);
      out_m[g]++;
      rr_m   = (g + 1) % N;
      lock_m = 0;
    end else if (issue) begin
      lock_m     = 1;
      lock_idx_m = g;
    end
    if (head < 0 && be_rsp_valid) unexp_m = 1;
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    be_rsp_valid = 1'b1;
    for (int k = 0; k < 3 * D && exp_q.size() > 0; k++) tick();
    be_rsp_valid = 1'b0;
    check("drain_done", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    for (int i = 0; i < N; i++) ch_req[i] = req_t'(16'hA000 + i);
    ch_req_valid = '0;
    ch_rsp_ready = '1;
    be_req_ready = 1'b1;
    be_rsp       = 8'h5A;
    be_rsp_valid = 1'b0;
    be_busy      = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_be_req_valid", be_req_valid, 1'b0);
    check("rst_ch_rsp_valid", ch_rsp_valid, '0);
    check("rst_be_rsp_ready", be_rsp_ready, 1'b0);
    check("rst_unexpected", rsp_unexp, 1'b0);
    check("rst_outstanding", ch_out, '0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Fairness: all channels valid, four grants fill the route FIFO, fifth sees full.
    ch_req_valid = '1;
    repeat (5) tick();
    // One pop while full: no push that cycle, request issues the next cycle.
    be_rsp_valid = 1'b1;
    tick();
    be_rsp_valid = 1'b0;
    tick();
    ch_req_valid = '0;

    // Response backpressure on the head channel.
    ch_rsp_ready = ~(4'(1) << exp_q[0]);
    be_rsp_valid = 1'b1;
    repeat (3) tick();
    be_rsp_valid = 1'b0;
    ch_rsp_ready = '1;
    be_busy      = 1'b1;
    drain();
    be_busy = 1'b0;

    // Lock stability: channels 1 and 3 valid, backend stalled for 5 cycles.
    ch_req_valid = 4'b1010;
    be_req_ready = 1'b0;
    repeat (3) tick();
    ch_req[3] = 16'hBEEF;
    repeat (2) tick();
    be_req_ready = 1'b1;
    repeat (2) tick();
    ch_req_valid = '0;
    tick();
    drain();

    // Routing order: ch2, ch0, ch2 then three responses.
    ch_req_valid = 4'b0100; tick();
    ch_req_valid = 4'b0001; tick();
    ch_req_valid = 4'b0100; tick();
    ch_req_valid = '0;
    check("route_out2", ch_out[2], 2);
    drain();

    // Simultaneous push and pop on channel 0.
    ch_req_valid = 4'b0001;
    tick();
    be_rsp_valid = 1'b1;
    repeat (3) tick();
    be_rsp_valid = 1'b0;
    ch_req_valid = '0;
    drain();

    // Unexpected response with the route FIFO empty; flag is sticky.
    be_rsp_valid = 1'b1;
    tick();
    be_rsp_valid = 1'b0;
    repeat (3) tick();

    // Asynchronous reset mid-transfer clears all state.
    ch_req_valid = 4'b0010;
    tick();
    ch_req_valid = '0;
    check("pre_rst_out1", ch_out[1], 1);
    rst_n = 1'b0;
    #1;
    check("async_rst_unexpected", rsp_unexp, 1'b0);
    check("async_rst_outstanding", ch_out, '0);
    check("async_rst_be_rsp_ready", be_rsp_ready, 1'b0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
